// File: rtl/bcd_ring_timer_if.sv
// bcd_ring_timer_if: control strobes, load data and status bundle
// for the multi-channel BCD ring timer.
interface bcd_ring_timer_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0]   load;
  logic [N_CH-1:0]   start;
  logic [N_CH-1:0]   pause;
  logic [N_CH-1:0]   apagar_alarma;
  logic [7:0]        hora_in;
  logic [7:0]        min_in;
  logic [7:0]        seg_in;
  logic [8*N_CH-1:0] hora_T;
  logic [8*N_CH-1:0] min_T;
  logic [8*N_CH-1:0] seg_T;
  logic [N_CH-1:0]   activring;
  logic [N_CH-1:0]   ring_blink;
  logic [N_CH-1:0]   running;
  logic              load_err;
  logic              tick;

  modport master (
    output load, start, pause, apagar_alarma,
    output hora_in, min_in, seg_in,
    input  hora_T, min_T, seg_T,
    input  activring, ring_blink, running,
    input  load_err, tick
  );

  modport slave (
    input  load, start, pause, apagar_alarma,
    input  hora_in, min_in, seg_in,
    output hora_T, min_T, seg_T,
    output activring, ring_blink, running,
    output load_err, tick
  );
endinterface

// File: rtl/bcd_ring_timer.sv
// bcd_ring_timer: N-channel hh:mm:ss BCD countdown timers with
// shared 1 Hz prescaler, ring timeout/acknowledge and blink.
module bcd_ring_timer #(
  parameter int         N_CH     = 2,
  parameter int         TICK_DIV = 100000000,
  parameter logic [7:0] HR_MAX   = 8'h23,
  parameter int         RING_SEC = 30
) (
  input logic             clk,
  input logic             reset,
  bcd_ring_timer_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    RING
  } st_t;

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          tick_q;
  logic          phase_q;
  logic          err_q;
  logic          err_d;
  logic          load_ok;

  st_t           st_q [N_CH];
  st_t           st_d [N_CH];
  logic [7:0]    hh_q [N_CH];
  logic [7:0]    hh_d [N_CH];
  logic [7:0]    mm_q [N_CH];
  logic [7:0]    mm_d [N_CH];
  logic [7:0]    ss_q [N_CH];
  logic [7:0]    ss_d [N_CH];
  logic [RW-1:0] rc_q [N_CH];
  logic [RW-1:0] rc_d [N_CH];
  logic [23:0]   dec_t [N_CH];

  function automatic logic bcd_ok(
    input logic [7:0] v,
    input logic [7:0] max
  );
    return (v[7:4] <= 4'd9) &&
           (v[3:0] <= 4'd9) &&
           (v <= max);
  endfunction

  function automatic logic [7:0] dec2(
    input logic [7:0] v,
    input logic [7:0] wrap
  );
    if (v == 8'h00)
      return wrap;
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // hours only borrow when mm:ss is 00:00
  function automatic logic [23:0] tdec(
    input logic [23:0] t
  );
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    h = t[23:16];
    m = t[15:8];
    s = t[7:0];
    if (s == 8'h00 && m == 8'h00)
      h = dec2(h, 8'h00);
    if (s == 8'h00)
      m = dec2(m, 8'h59);
    s = dec2(s, 8'h59);
    return {h, m, s};
  endfunction

  assign load_ok = bcd_ok(bus.hora_in, HR_MAX) &&
                   bcd_ok(bus.min_in, 8'h59) &&
                   bcd_ok(bus.seg_in, 8'h59);

  assign pre_d = (pre_q == PW'(TICK_DIV - 1)) ?
                 '0 : pre_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      phase_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= (pre_d == PW'(TICK_DIV - 1));
      phase_q <= phase_q ^ tick_q;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++)
      dec_t[i] = tdec({hh_q[i], mm_q[i], ss_q[i]});
  end

  always_comb begin
    err_d = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      st_d[i] = st_q[i];
      hh_d[i] = hh_q[i];
      mm_d[i] = mm_q[i];
      ss_d[i] = ss_q[i];
      rc_d[i] = rc_q[i];
      if (bus.apagar_alarma[i]) begin
        st_d[i] = IDLE;
      end else if (bus.load[i] && st_q[i] != RING) begin
        if (load_ok) begin
          hh_d[i] = bus.hora_in;
          mm_d[i] = bus.min_in;
          ss_d[i] = bus.seg_in;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        unique case (st_q[i])
          IDLE: begin
            if (bus.start[i] &&
                {hh_q[i], mm_q[i], ss_q[i]} != 24'h0)
              st_d[i] = RUN;
          end
          RUN: begin
            if (bus.pause[i]) begin
              st_d[i] = PAUSED;
            end else if (tick_q) begin
              if ({hh_q[i], mm_q[i], ss_q[i]} != 24'h0) begin
                hh_d[i] = dec_t[i][23:16];
                mm_d[i] = dec_t[i][15:8];
                ss_d[i] = dec_t[i][7:0];
              end
              if ({hh_q[i], mm_q[i], ss_q[i]} == 24'h0 ||
                  dec_t[i] == 24'h0) begin
                st_d[i] = RING;
                rc_d[i] = '0;
              end
            end
          end
          PAUSED: begin
            if (bus.start[i])
              st_d[i] = RUN;
          end
          RING: begin
            if (tick_q) begin
              if (rc_q[i] == RW'(RING_SEC - 1))
                st_d[i] = IDLE;
              else
                rc_d[i] = rc_q[i] + 1'b1;
            end
          end
          default: st_d[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i] <= IDLE;
        hh_q[i] <= 8'h00;
        mm_q[i] <= 8'h00;
        ss_q[i] <= 8'h00;
        rc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i] <= st_d[i];
        hh_q[i] <= hh_d[i];
        mm_q[i] <= mm_d[i];
        ss_q[i] <= ss_d[i];
        rc_q[i] <= rc_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign bus.hora_T[8*g +: 8] = hh_q[g];
    assign bus.min_T[8*g +: 8]  = mm_q[g];
    assign bus.seg_T[8*g +: 8]  = ss_q[g];
    assign bus.activring[g]     = (st_q[g] == RING);
    assign bus.ring_blink[g]    = (st_q[g] == RING) & phase_q;
    assign bus.running[g]       = (st_q[g] == RUN);
  end

  assign bus.tick     = tick_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_ring_timer.sv
// tb_bcd_ring_timer: directed bench for bcd_ring_timer with
// TICK_DIV=4, N_CH=2, RING_SEC=3.
module tb_bcd_ring_timer;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   m_cnt;
  logic m_ph;

  bcd_ring_timer_if #(.N_CH(2)) intf ();

  bcd_ring_timer #(
    .N_CH(2),
    .TICK_DIV(4),
    .HR_MAX(8'h23),
    .RING_SEC(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(intf)
  );

  always #5 clk = ~clk;

  // independent prescaler/phase model
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt <= 0;
      m_ph  <= 1'b0;
    end else if (m_cnt == 3) begin
      m_cnt <= 0;
      m_ph  <= ~m_ph;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_time(input logic [7:0] h, m, s);
    intf.hora_in = h;
    intf.min_in  = m;
    intf.seg_in  = s;
  endtask

  task automatic strobe(input logic [1:0] ld, st, ps, ap);
    intf.load          = ld;
    intf.start         = st;
    intf.pause         = ps;
    intf.apagar_alarma = ap;
    @(negedge clk);
    intf.load          = '0;
    intf.start         = '0;
    intf.pause         = '0;
    intf.apagar_alarma = '0;
  endtask

  task automatic do_tick(input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (intf.tick !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      tests++;
      if (intf.tick !== 1'b1) begin
        fails++;
        $display("FAIL tick_wait: tick=%b want 1", intf.tick);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    intf.load = '0; intf.start = '0;
    intf.pause = '0; intf.apagar_alarma = '0;
    set_time(8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    tests++; if (intf.hora_T !== 16'h0) begin fails++; $display("FAIL rst_hora: got %h want 0000", intf.hora_T); end
    tests++; if (intf.min_T !== 16'h0) begin fails++; $display("FAIL rst_min: got %h want 0000", intf.min_T); end
    tests++; if (intf.seg_T !== 16'h0) begin fails++; $display("FAIL rst_seg: got %h want 0000", intf.seg_T); end
    tests++; if (intf.activring !== 2'b00) begin fails++; $display("FAIL rst_ring: got %b want 00", intf.activring); end
    tests++; if (intf.ring_blink !== 2'b00) begin fails++; $display("FAIL rst_blink: got %b want 00", intf.ring_blink); end
    tests++; if (intf.running !== 2'b00) begin fails++; $display("FAIL rst_run: got %b want 00", intf.running); end
    tests++; if (intf.load_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", intf.load_err); end
    tests++; if (intf.tick !== 1'b0) begin fails++; $display("FAIL rst_tick: got %b want 0", intf.tick); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_countdown();
    set_time(8'h00, 8'h01, 8'h00);
    strobe(2'b01, 2'b00, 2'b00, 2'b00);
    tests++; if ({intf.min_T[7:0], intf.seg_T[7:0]} !== 16'h0100) begin fails++; $display("FAIL load_lat: got %h want 0100", {intf.min_T[7:0], intf.seg_T[7:0]}); end
    strobe(2'b00, 2'b01, 2'b00, 2'b00);
    tests++; if (intf.running !== 2'b01) begin fails++; $display("FAIL start_run: got %b want 01", intf.running); end
    do_tick(1);
    tests++; if ({intf.min_T[7:0], intf.seg_T[7:0]} !== 16'h0059) begin fails++; $display("FAIL first_dec: got %h want 0059", {intf.min_T[7:0], intf.seg_T[7:0]}); end
    do_tick(58);
    tests++; if (intf.seg_T[7:0] !== 8'h01) begin fails++; $display("FAIL dec58: got %h want 01", intf.seg_T[7:0]); end
    tests++; if (intf.activring[0] !== 1'b0) begin fails++; $display("FAIL early_ring: got %b want 0", intf.activring[0]); end
    do_tick(1);
    tests++; if (intf.activring !== 2'b01) begin fails++; $display("FAIL ring_entry: got %b want 01", intf.activring); end
    tests++; if (intf.running !== 2'b00) begin fails++; $display("FAIL ring_run: got %b want 00", intf.running); end
    tests++; if (intf.seg_T[7:0] !== 8'h00) begin fails++; $display("FAIL ring_time: got %h want 00", intf.seg_T[7:0]); end
    tests++; if ({intf.hora_T[15:8], intf.min_T[15:8], intf.seg_T[15:8]} !== 24'h0) begin fails++; $display("FAIL ch1_time: got %h want 000000", {intf.hora_T[15:8], intf.min_T[15:8], intf.seg_T[15:8]}); end
  endtask

  task automatic test_ring_end();
    logic b0;
    tests++; if (intf.ring_blink[0] !== m_ph) begin fails++; $display("FAIL blink0: got %b want %b", intf.ring_blink[0], m_ph); end
    b0 = intf.ring_blink[0];
    do_tick(1);
    tests++; if (intf.ring_blink[0] !== m_ph) begin fails++; $display("FAIL blink1: got %b want %b", intf.ring_blink[0], m_ph); end
    tests++; if (intf.ring_blink[0] === b0) begin fails++; $display("FAIL blink_tog: got %b want %b", intf.ring_blink[0], ~b0); end
    do_tick(1);
    tests++; if (intf.activring[0] !== 1'b1) begin fails++; $display("FAIL ring_hold: got %b want 1", intf.activring[0]); end
    do_tick(1);
    tests++; if (intf.activring !== 2'b00) begin fails++; $display("FAIL ring_timeout: got %b want 00", intf.activring); end
    tests++; if (intf.ring_blink !== 2'b00) begin fails++; $display("FAIL blink_off: got %b want 00", intf.ring_blink); end
    set_time(8'h00, 8'h00, 8'h02);
    strobe(2'b01, 2'b00, 2'b00, 2'b00);
    strobe(2'b00, 2'b01, 2'b00, 2'b00);
    do_tick(2);
    tests++; if (intf.activring[0] !== 1'b1) begin fails++; $display("FAIL ring2: got %b want 1", intf.activring[0]); end
    strobe(2'b00, 2'b00, 2'b00, 2'b01);
    tests++; if (intf.activring[0] !== 1'b0) begin fails++; $display("FAIL ack: got %b want 0", intf.activring[0]); end
    tests++; if (intf.running[0] !== 1'b0) begin fails++; $display("FAIL ack_run: got %b want 0", intf.running[0]); end
  endtask

  task automatic test_borrow();
    set_time(8'h01, 8'h00, 8'h00);
    strobe(2'b01, 2'b00, 2'b00, 2'b00);
    strobe(2'b00, 2'b01, 2'b00, 2'b00);
    do_tick(1);
    tests++; if ({intf.hora_T[7:0], intf.min_T[7:0], intf.seg_T[7:0]} !== 24'h005959) begin fails++; $display("FAIL borrow_h: got %h want 005959", {intf.hora_T[7:0], intf.min_T[7:0], intf.seg_T[7:0]}); end
    set_time(8'h10, 8'h00, 8'h00);
    strobe(2'b01, 2'b00, 2'b00, 2'b00);
    tests++; if (intf.running[0] !== 1'b1) begin fails++; $display("FAIL load_run: got %b want 1", intf.running[0]); end
    do_tick(1);
    tests++; if ({intf.hora_T[7:0], intf.min_T[7:0], intf.seg_T[7:0]} !== 24'h095959) begin fails++; $display("FAIL borrow_10: got %h want 095959", {intf.hora_T[7:0], intf.min_T[7:0], intf.seg_T[7:0]}); end
    strobe(2'b00, 2'b00, 2'b00, 2'b01);
    tests++; if (intf.running[0] !== 1'b0) begin fails++; $display("FAIL stop_run: got %b want 0", intf.running[0]); end
    tests++; if (intf.seg_T[7:0] !== 8'h59) begin fails++; $display("FAIL stop_keep: got %h want 59", intf.seg_T[7:0]); end
  endtask

  task automatic test_invalid();
    set_time(8'h01, 8'h00, 8'h60);
    strobe(2'b01, 2'b00, 2'b00, 2'b00);
    tests++; if (intf.load_err !== 1'b1) begin fails++; $display("FAIL err_seg: got %b want 1", intf.load_err); end
    tests++; if ({intf.hora_T[7:0], intf.seg_T[7:0]} !== 16'h0959) begin fails++; $display("FAIL err_keep: got %h want 0959", {intf.hora_T[7:0], intf.seg_T[7:0]}); end
    @(negedge clk);
    tests++; if (intf.load_err !== 1'b0) begin fails++; $display("FAIL err_pulse: got %b want 0", intf.load_err); end
    set_time(8'h24, 8'h00, 8'h00);
    strobe(2'b11, 2'b00, 2'b00, 2'b00);
    tests++; if (intf.load_err !== 1'b1) begin fails++; $display("FAIL err_hr: got %b want 1", intf.load_err); end
    @(negedge clk);
    tests++; if (intf.load_err !== 1'b0) begin fails++; $display("FAIL err_single: got %b want 0", intf.load_err); end
    set_time(8'h23, 8'h00, 8'h00);
    strobe(2'b01, 2'b00, 2'b00, 2'b00);
    tests++; if (intf.load_err !== 1'b0) begin fails++; $display("FAIL ok_hr: got %b want 0", intf.load_err); end
    tests++; if (intf.hora_T[7:0] !== 8'h23) begin fails++; $display("FAIL hr23: got %h want 23", intf.hora_T[7:0]); end
    set_time(8'h00, 8'h1A, 8'h00);
    strobe(2'b01, 2'b00, 2'b00, 2'b00);
    tests++; if (intf.load_err !== 1'b1) begin fails++; $display("FAIL err_nib: got %b want 1", intf.load_err); end
    tests++; if ({intf.hora_T[7:0], intf.min_T[7:0]} !== 16'h2300) begin fails++; $display("FAIL nib_keep: got %h want 2300", {intf.hora_T[7:0], intf.min_T[7:0]}); end
  endtask

  task automatic test_priority();
    set_time(8'h00, 8'h00, 8'h05);
    strobe(2'b01, 2'b01, 2'b00, 2'b00);
    tests++; if (intf.running[0] !== 1'b0) begin fails++; $display("FAIL ld_st_run: got %b want 0", intf.running[0]); end
    tests++; if ({intf.hora_T[7:0], intf.seg_T[7:0]} !== 16'h0005) begin fails++; $display("FAIL ld_st_val: got %h want 0005", {intf.hora_T[7:0], intf.seg_T[7:0]}); end
    strobe(2'b00, 2'b01, 2'b00, 2'b00);
    do_tick(1);
    tests++; if (intf.seg_T[7:0] !== 8'h04) begin fails++; $display("FAIL pr_dec: got %h want 04", intf.seg_T[7:0]); end
    strobe(2'b00, 2'b00, 2'b01, 2'b00);
    tests++; if (intf.running[0] !== 1'b0) begin fails++; $display("FAIL pause_run: got %b want 0", intf.running[0]); end
    do_tick(5);
    tests++; if (intf.seg_T[7:0] !== 8'h04) begin fails++; $display("FAIL frozen: got %h want 04", intf.seg_T[7:0]); end
    strobe(2'b00, 2'b01, 2'b00, 2'b00);
    tests++; if (intf.running[0] !== 1'b1) begin fails++; $display("FAIL resume: got %b want 1", intf.running[0]); end
    do_tick(1);
    tests++; if (intf.seg_T[7:0] !== 8'h03) begin fails++; $display("FAIL resume_dec: got %h want 03", intf.seg_T[7:0]); end
    strobe(2'b00, 2'b00, 2'b00, 2'b01);
    strobe(2'b00, 2'b10, 2'b00, 2'b00);
    tests++; if (intf.running[1] !== 1'b0) begin fails++; $display("FAIL start_zero: got %b want 0", intf.running[1]); end
  endtask

  task automatic test_async_reset();
    int n;
    set_time(8'h00, 8'h00, 8'h01);
    strobe(2'b01, 2'b00, 2'b00, 2'b00);
    strobe(2'b00, 2'b01, 2'b00, 2'b00);
    do_tick(1);
    set_time(8'h00, 8'h05, 8'h00);
    strobe(2'b10, 2'b00, 2'b00, 2'b00);
    strobe(2'b00, 2'b10, 2'b00, 2'b00);
    tests++; if ({intf.running[1], intf.activring[0]} !== 2'b11) begin fails++; $display("FAIL pre_rst: got %b want 11", {intf.running[1], intf.activring[0]}); end
    #2 reset = 1'b0;
    #1;
    tests++; if ({intf.hora_T, intf.min_T, intf.seg_T} !== 48'h0) begin fails++; $display("FAIL arst_time: got %h want 0", {intf.hora_T, intf.min_T, intf.seg_T}); end
    tests++; if ({intf.activring, intf.running, intf.ring_blink} !== 6'b0) begin fails++; $display("FAIL arst_flags: got %b want 000000", {intf.activring, intf.running, intf.ring_blink}); end
    tests++; if ({intf.tick, intf.load_err} !== 2'b00) begin fails++; $display("FAIL arst_tick: got %b want 00", {intf.tick, intf.load_err}); end
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (intf.tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++; if (n !== 3) begin fails++; $display("FAIL first_tick: got %0d edges want 3", n); end
    tests++; if (intf.running !== 2'b00) begin fails++; $display("FAIL post_rst: got %b want 00", intf.running); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_countdown();
    test_ring_end();
    test_borrow();
    test_invalid();
    test_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
